oam_dma_arbiter_m: RTL and testbench

//  Owns the single OAM RAM port (0xFE00-0xFE9F) and shares it between three requesters: the PPU, the OAM DMA engine and the CPU.

---
 rtl/oam_dma_arbiter_m.sv | 212 +++++++++++++++++++++
 tb/tb_oam_dma_arbiter_m.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma_arbiter_m.sv
// ---------------------------------------------------------------------------
// oam_dma_arbiter_m
//
// Owns the single OAM RAM port (0xFE00-0xFE9F) and shares it between the PPU,
// the OAM DMA engine and the CPU (priority PPU > DMA > CPU). Also implements
// the DMA register 0xFF46: a CPU write there starts a DMA_LEN-byte copy from
// {src,8'h00} into OAM.
//
// Ports
//   clk, rst             system clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata CPU access strobe (1-cycle pulse) and payload
//   cpu_rdata, cpu_ack    read data + acknowledge, exactly 1 cycle after req
//   src_rd, src_addr      DMA source read strobe and address
//   src_rdata             DMA source data, SRC_RD_LAT cycles after src_rd
//   ppu_oam_lock          PPU owns OAM while high (modes 2/3)
//   ppu_oam_addr/rdata    PPU OAM read index and returned data
//   oam_addr/wdata/we     OAM RAM port (index 0..159)
//   oam_rdata             OAM RAM read data, 1-cycle latency
//   dma_active            DMA in progress (START through last WR)
//
// Parameters: START_DLY and SRC_RD_LAT must both be >= 1.
// ---------------------------------------------------------------------------
module oam_dma_arbiter_m #(
    parameter int DMA_LEN    = 160,
    parameter int SRC_RD_LAT = 1,
    parameter int START_DLY  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_ack,
    output logic        src_rd,
    output logic [15:0] src_addr,
    input  logic [7:0]  src_rdata,
    input  logic        ppu_oam_lock,
    input  logic [7:0]  ppu_oam_addr,
    output logic [7:0]  ppu_oam_rdata,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_wdata,
    output logic        oam_we,
    input  logic [7:0]  oam_rdata,
    output logic        dma_active
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_RD,
        S_WAIT,
        S_WR
    } state_t;

    localparam logic [7:0] LAST_IDX   = 8'(DMA_LEN - 1);
    localparam logic [7:0] START_LAST = 8'(START_DLY - 1);
    localparam logic [7:0] WAIT_LAST  = 8'(SRC_RD_LAT - 1);

    state_t     state;
    logic [7:0] dma_reg;
    logic [7:0] cnt;
    logic [7:0] dly;
    logic [7:0] data_q;

    logic       ack_q;
    logic       rd_oam_q;   // ack cycle returns live OAM data
    logic [7:0] rdata_q;    // ack cycle returns this constant/register value

    // -----------------------------------------------------------------------
    // CPU address decode
    // -----------------------------------------------------------------------
    logic is_ff46;
    logic is_oam;
    logic dma_go;
    logic oam_blocked;
    logic cpu_oam;
    logic [7:0] src_hi;

    assign is_ff46     = (cpu_addr == 16'hFF46);
    assign is_oam      = (cpu_addr[15:8] == 8'hFE) && (cpu_addr[7:0] < 8'hA0);
    assign dma_go      = cpu_req && cpu_we && is_ff46;
    assign oam_blocked = ppu_oam_lock || dma_active;
    assign cpu_oam     = cpu_req && is_oam && !oam_blocked;

    assign dma_active  = (state != S_IDLE);
    assign src_rd      = (state == S_RD);

    // Pages 0xE0-0xFF are echo RAM: fold them back onto 0xC0-0xDF.
    assign src_hi      = (dma_reg < 8'hE0) ? dma_reg : (dma_reg - 8'h20);
    assign src_addr    = {src_hi, cnt};

    assign ppu_oam_rdata = oam_rdata;

    // -----------------------------------------------------------------------
    // OAM port mux, priority PPU > DMA > CPU
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path through the if/else chain leaves it unassigned (latch).
        oam_addr  = 8'h00;
        oam_wdata = 8'h00;
        oam_we    = 1'b0;
        if (ppu_oam_lock) begin
            oam_addr = ppu_oam_addr;
        end else if (state == S_WR) begin
            oam_addr  = cnt;
            oam_wdata = data_q;
            oam_we    = 1'b1;
        end else if (cpu_oam) begin
            oam_addr  = cpu_addr[7:0];
            oam_wdata = cpu_wdata;
            oam_we    = cpu_we;
        end
    end

    // -----------------------------------------------------------------------
    // CPU side: FF46 register, ack and read-data selection
    // -----------------------------------------------------------------------
    // OAM reads are only known in the ack cycle (synchronous RAM), so the
    // return path selects between the live RAM output and a registered value.
    assign cpu_ack   = ack_q;
    assign cpu_rdata = rd_oam_q ? oam_rdata : rdata_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: sequential state is assigned with <= so every register
            // samples the pre-edge values of its neighbours.
            ack_q    <= 1'b0;
            rd_oam_q <= 1'b0;
            rdata_q  <= 8'h00;
            dma_reg  <= 8'h00;
        end else begin
            ack_q    <= cpu_req;
            rd_oam_q <= 1'b0;
            rdata_q  <= 8'h00;
            if (dma_go) begin
                dma_reg <= cpu_wdata;
            end
            if (cpu_req && !cpu_we) begin
                if (is_ff46) begin
                    rdata_q <= dma_reg;
                end else if (is_oam) begin
                    if (oam_blocked) begin
                        rdata_q <= 8'hFF;
                    end else begin
                        rd_oam_q <= 1'b1;
                    end
                end
                // 0xFEA0-0xFEFF reads fall through and return 8'h00.
            end
        end
    end

    // -----------------------------------------------------------------------
    // DMA engine: IDLE -> START -> RD -> WAIT -> WR -> (RD | IDLE)
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            cnt    <= 8'h00;
            dly    <= 8'h00;
            data_q <= 8'h00;
        end else if (dma_go) begin
            // A new FF46 write always wins: any in-flight byte is abandoned.
            // A WR in this same cycle still lands, since the port mux only
            // looks at the current state.
            state <= S_START;
            cnt   <= 8'h00;
            dly   <= START_LAST;
        end else begin
            case (state)
                S_START: begin
                    if (dly == 8'h00) begin
                        state <= S_RD;
                    end else begin
                        dly <= dly - 8'h01;
                    end
                end
                S_RD: begin
                    state <= S_WAIT;
                    dly   <= WAIT_LAST;
                end
                S_WAIT: begin
                    if (dly == 8'h00) begin
                        data_q <= src_rdata;
                        state  <= S_WR;
                    end else begin
                        dly <= dly - 8'h01;
                    end
                end
                S_WR: begin
                    // The PPU holds the port: the write is stalled, not lost.
                    if (!ppu_oam_lock) begin
                        if (cnt == LAST_IDX) begin
                            state <= S_IDLE;
                            cnt   <= 8'h00;
                        end else begin
                            cnt   <= cnt + 8'h01;
                            state <= S_RD;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_oam_dma_arbiter_m.sv
// ---------------------------------------------------------------------------
// tb_oam_dma_arbiter_m
//
// Self-checking bench for oam_dma_arbiter_m. The bench provides the OAM RAM
// and the DMA source memory, and keeps a reference model that describes the
// DMA as a position on a byte timeline (byte = pos / period, slot = pos %
// period) plus an expected OAM image.
// ---------------------------------------------------------------------------
module tb_oam_dma_arbiter_m;

    localparam int LEN  = 160;
    localparam int LAT  = 1;
    localparam int SDLY = 1;
    localparam int P    = LAT + 2;   // cycles per copied byte

    logic        clk;
    logic        rst;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_ack;
    logic        src_rd;
    logic [15:0] src_addr;
    logic [7:0]  src_rdata;
    logic        ppu_oam_lock;
    logic [7:0]  ppu_oam_addr;
    logic [7:0]  ppu_oam_rdata;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_wdata;
    logic        oam_we;
    logic [7:0]  oam_rdata;
    logic        dma_active;

    oam_dma_arbiter_m #(
        .DMA_LEN    (LEN),
        .SRC_RD_LAT (LAT),
        .START_DLY  (SDLY)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cpu_req       (cpu_req),
        .cpu_we        (cpu_we),
        .cpu_addr      (cpu_addr),
        .cpu_wdata     (cpu_wdata),
        .cpu_rdata     (cpu_rdata),
        .cpu_ack       (cpu_ack),
        .src_rd        (src_rd),
        .src_addr      (src_addr),
        .src_rdata     (src_rdata),
        .ppu_oam_lock  (ppu_oam_lock),
        .ppu_oam_addr  (ppu_oam_addr),
        .ppu_oam_rdata (ppu_oam_rdata),
        .oam_addr      (oam_addr),
        .oam_wdata     (oam_wdata),
        .oam_we        (oam_we),
        .oam_rdata     (oam_rdata),
        .dma_active    (dma_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Source memory content is a fixed function of the address.
    function automatic logic [7:0] src_byte(input logic [15:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h3C;
    endfunction

    function automatic logic [7:0] hi_of(input logic [7:0] r);
        return (r < 8'hE0) ? r : r - 8'h20;
    endfunction

    function automatic bit is_oam_addr(input logic [15:0] a);
        return (a[15:8] == 8'hFE) && (a[7:0] < 8'hA0);
    endfunction

    // ---------------- bench-side memories ----------------
    logic       mem_init;
    logic [7:0] oam_mem [0:255];
    logic [7:0] src_pipe [0:LAT-1];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) oam_mem[i] <= 8'h00;
            oam_rdata <= 8'h00;
        end else begin
            if (oam_we) oam_mem[oam_addr] <= oam_wdata;
            oam_rdata <= oam_mem[oam_addr];
        end
    end

    // Data only appears exactly LAT cycles after a strobe; filler otherwise.
    always @(posedge clk) begin
        src_pipe[0] <= src_rd ? src_byte(src_addr) : 8'hEE;
        for (int i = 1; i < LAT; i++) src_pipe[i] <= src_pipe[i-1];
    end
    assign src_rdata = src_pipe[LAT-1];

    // ---------------- reference model ----------------
    bit         m_active;
    int         m_start_left;
    int         m_pos;
    logic [7:0] m_reg;
    bit         m_ack;
    logic [7:0] m_rd;
    logic [7:0] exp_oam [0:255];

    int total;
    int bad;
    int active_cycles;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active     = 0;
        m_start_left = 0;
        m_pos        = 0;
        m_reg        = 8'h00;
        m_ack        = 0;
        m_rd         = 8'h00;
    endtask

    // Compare every DUT output against the model for the current cycle.
    task automatic check_cycle();
        int         b;
        int         s;
        bit         in_loop;
        bit         e_rd;
        bit         e_wr;
        bit         e_cpu;
        logic [7:0] hi;
        b       = m_pos / P;
        s       = m_pos % P;
        in_loop = m_active && (m_start_left == 0);
        e_rd    = in_loop && (s == 0);
        e_wr    = in_loop && (s == P - 1);
        hi      = hi_of(m_reg);
        if (dma_active === 1'b1) active_cycles++;
        check("dma_active", dma_active, m_active);
        check("src_rd", src_rd, e_rd);
        if (e_rd) check("src_addr", src_addr, {hi, 8'(b)});
        if (ppu_oam_lock) begin
            check("oam_we_lock", oam_we, 0);
            check("oam_addr_ppu", oam_addr, ppu_oam_addr);
        end else if (e_wr) begin
            check("oam_we_dma", oam_we, 1);
            check("oam_addr_dma", oam_addr, b);
            check("oam_wdata_dma", oam_wdata, src_byte({hi, 8'(b)}));
        end else begin
            e_cpu = cpu_req && is_oam_addr(cpu_addr) && !m_active;
            check("oam_we_cpu", oam_we, e_cpu && cpu_we);
            if (e_cpu) check("oam_addr_cpu", oam_addr, cpu_addr[7:0]);
            if (e_cpu && cpu_we) check("oam_wdata_cpu", oam_wdata, cpu_wdata);
        end
        check("cpu_ack", cpu_ack, m_ack);
        if (m_ack) check("cpu_rdata", cpu_rdata, m_rd);
        check("ppu_rdata", ppu_oam_rdata, oam_rdata);
    endtask

    // Advance the model across one rising edge using this cycle's inputs.
    task automatic model_update();
        int         b;
        int         s;
        bit         in_loop;
        bit         e_wr;
        bit         restart;
        b       = m_pos / P;
        s       = m_pos % P;
        in_loop = m_active && (m_start_left == 0);
        e_wr    = in_loop && (s == P - 1);
        restart = cpu_req && cpu_we && (cpu_addr == 16'hFF46);

        if (e_wr && !ppu_oam_lock) exp_oam[b] = src_byte({hi_of(m_reg), 8'(b)});

        m_ack = cpu_req;
        m_rd  = 8'h00;
        if (cpu_req) begin
            if (cpu_addr == 16'hFF46) begin
                if (!cpu_we) m_rd = m_reg;
            end else if (is_oam_addr(cpu_addr)) begin
                if (ppu_oam_lock || m_active) begin
                    if (!cpu_we) m_rd = 8'hFF;
                end else if (cpu_we) begin
                    exp_oam[cpu_addr[7:0]] = cpu_wdata;
                end else begin
                    m_rd = exp_oam[cpu_addr[7:0]];
                end
            end
        end

        if (restart) begin
            m_reg        = cpu_wdata;
            m_active     = 1;
            m_start_left = SDLY;
            m_pos        = 0;
        end else if (in_loop) begin
            if (e_wr) begin
                if (!ppu_oam_lock) begin
                    if (b == LEN - 1) m_active = 0;
                    else m_pos++;
                end
            end else begin
                m_pos++;
            end
        end else if (m_active) begin
            m_start_left--;
        end
    endtask

    // One clock cycle: inputs are already driven (just after the falling edge).
    task automatic step();
        #2;
        check_cycle();
        @(posedge clk);
        model_update();
        @(negedge clk);
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
    endtask

    task automatic cpu(input bit we, input logic [15:0] a, input logic [7:0] d);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = d;
        step();
    endtask

    task automatic wait_done(input int bound);
        int k;
        k = 0;
        while (dma_active === 1'b1 && k < bound) begin
            step();
            k++;
        end
        check("dma_done_in_time", k < bound, 1);
    endtask

    task automatic wait_pos(input int b, input int s, input int bound);
        int k;
        k = 0;
        while (!(m_active && m_start_left == 0 && m_pos == b * P + s) && k < bound) begin
            step();
            k++;
        end
        check("reach_byte_in_time", k < bound, 1);
    endtask

    function automatic int page_errors(input logic [7:0] page);
        int e;
        e = 0;
        for (int i = 0; i < LEN; i++)
            if (oam_mem[i] !== src_byte({hi_of(page), 8'(i)})) e++;
        return e;
    endfunction

    initial begin
        total = 0;
        bad   = 0;
        active_cycles = 0;
        rst          = 1'b0;
        mem_init     = 1'b1;
        cpu_req      = 1'b0;
        cpu_we       = 1'b0;
        cpu_addr     = 16'h0000;
        cpu_wdata    = 8'h00;
        ppu_oam_lock = 1'b0;
        ppu_oam_addr = 8'h00;
        model_reset();
        for (int i = 0; i < 256; i++) exp_oam[i] = 8'h00;

        // Reset state
        repeat (2) @(negedge clk);
        #2;
        check("rst_cpu_ack", cpu_ack, 0);
        check("rst_cpu_rdata", cpu_rdata, 0);
        check("rst_src_rd", src_rd, 0);
        check("rst_src_addr", src_addr, 0);
        check("rst_oam_we", oam_we, 0);
        check("rst_oam_addr", oam_addr, 0);
        check("rst_oam_wdata", oam_wdata, 0);
        check("rst_dma_active", dma_active, 0);
        @(negedge clk);
        rst      = 1'b1;
        mem_init = 1'b0;
        step();

        // 1: plain DMA from 0xC100
        active_cycles = 0;
        cpu(1, 16'hFF46, 8'hC1);
        wait_done(2000);
        check("t1_duration", active_cycles, 481);
        check("t1_oam_errors", page_errors(8'hC1), 0);

        // 2: CPU OAM access during DMA is blocked
        cpu(1, 16'hFF46, 8'hC3);
        repeat (5) step();
        cpu(0, 16'hFE10, 8'h00);
        #1 check("t2_ack", cpu_ack, 1);
        check("t2_rdata_ff", cpu_rdata, 8'hFF);
        wait_pos(8'h20, 0, 1000);
        cpu(1, 16'hFE10, 8'h55);
        wait_done(2000);
        check("t2_oam10_kept", oam_mem[8'h10], src_byte(16'hC310));

        // 3: PPU lock for 10 cycles while WR of byte 40 is pending
        active_cycles = 0;
        cpu(1, 16'hFF46, 8'hC4);
        wait_pos(40, P - 1, 1000);
        ppu_oam_lock = 1'b1;
        for (int i = 0; i < 10; i++) begin
            ppu_oam_addr = 8'($urandom_range(0, 159));
            step();
        end
        ppu_oam_lock = 1'b0;
        wait_done(2000);
        check("t3_duration", active_cycles, 491);
        check("t3_oam_errors", page_errors(8'hC4), 0);

        // 4: restart to 0xC2 at byte 50
        cpu(1, 16'hFF46, 8'hC6);
        wait_pos(50, 1, 1000);
        cpu(1, 16'hFF46, 8'hC2);
        wait_done(2000);
        check("t4_oam_errors", page_errors(8'hC2), 0);

        // 5: echo-RAM fold, 0xF0 reads from 0xD000
        cpu(1, 16'hFF46, 8'hF0);
        wait_pos(0, 0, 100);
        #1 check("t5_src_addr", src_addr, 16'hD000);
        cpu(0, 16'hFF46, 8'h00);
        #1 check("t5_ff46_read", cpu_rdata, 8'hF0);
        wait_done(2000);
        check("t5_oam_errors", page_errors(8'hF0), 0);

        // 6: asynchronous reset in the middle of a DMA
        cpu(1, 16'hFF46, 8'hC7);
        wait_pos(80, 0, 1000);
        #1 rst = 1'b0;
        #1;
        check("t6_dma_active", dma_active, 0);
        check("t6_src_rd", src_rd, 0);
        check("t6_src_addr", src_addr, 0);
        check("t6_oam_we", oam_we, 0);
        check("t6_cpu_ack", cpu_ack, 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        cpu(0, 16'hFF46, 8'h00);
        #1 check("t6_ff46_zero", cpu_rdata, 8'h00);
        cpu(1, 16'hFE00, 8'hAB);
        cpu(0, 16'hFE00, 8'h00);
        #1 check("t6_fe00_read", cpu_rdata, 8'hAB);
        step();

        // Randomized traffic against the model
        for (int n = 0; n < 6000; n++) begin
            int sel;
            if ($urandom_range(0, 15) == 0) ppu_oam_lock = !ppu_oam_lock;
            ppu_oam_addr = 8'($urandom_range(0, 159));
            if ($urandom_range(0, 4) == 0) begin
                sel       = $urandom_range(0, 99);
                cpu_req   = 1'b1;
                cpu_we    = 1'($urandom_range(0, 1));
                cpu_wdata = 8'($urandom);
                if (sel < 2) begin
                    cpu_we   = 1'b1;
                    cpu_addr = 16'hFF46;
                end else if (sel < 10) begin
                    cpu_we   = 1'b0;
                    cpu_addr = 16'hFF46;
                end else if (sel < 70) begin
                    cpu_addr = 16'hFE00 + 16'($urandom_range(0, 159));
                end else begin
                    cpu_addr = 16'hFEA0 + 16'($urandom_range(0, 95));
                end
            end
            step();
        end
        ppu_oam_lock = 1'b0;
        wait_done(3000);
        begin
            int e;
            e = 0;
            for (int i = 0; i < 256; i++)
                if (oam_mem[i] !== exp_oam[i]) e++;
            check("final_oam_image", e, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "time limit");
    end

endmodule
